uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver; sits directly downstream of uart_tx on the serial line.
- Recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from the asynchronous `rx` pin using mid-bit sampling.
- Presents each byte on a valid/ready output register; flags framing errors and overruns.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, line bit rate in Hz.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (derived localparam), clocks per bit. Elaboration error if < 4.
- HALF_BIT, CLKS_PER_BIT/2 (derived localparam), integer division.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, asynchronous to clk, idles high.
- rx_data  output  8  last received byte.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while rx_valid was high and no handshake occurred that cycle.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Synchroniser: two flops feed rx into rx_s. Both flops reset to 1. Adds 2 cycles of latency.
- Internal signal `state` is 4-bit one-hot: IDLE=0001, START=0010, DATA=0100, STOP=1000. The bench probes it hierarchically as DUT.state.
- The bit counter is cleared on every state entry.
- IDLE: rx_s==0 moves to START.
- START: at count HALF_BIT-1, sample rx_s.
  - rx_s==0: move to DATA.
  - rx_s==1: false start; return to IDLE with no flags.
- DATA: at count CLKS_PER_BIT-1, sample rx_s.
  - Shift the sample in at the MSB of the shift register (shift right).
  - Increment bit_idx (0..7).
  - After the sample with bit_idx==7, move to STOP.
- STOP: at count CLKS_PER_BIT-1, sample rx_s and return to IDLE in that same cycle. The receiver re-arms at mid-stop-bit, so back-to-back frames are accepted.
  - rx_s==1, rx_valid==0 or a handshake this cycle: load rx_data from the shift register and set rx_valid next cycle.
  - rx_s==1, rx_valid==1 and rx_ready==0: new byte is discarded, rx_data is unchanged, overrun pulses for 1 cycle.
  - rx_s==0: frame_err pulses for 1 cycle; byte is discarded; rx_valid and rx_data are unchanged.
- rx_valid clears the cycle after rx_valid && rx_ready, unless a new byte loads in that same cycle, in which case it stays high.
- Reset, at any time including mid-frame:
  - state=IDLE, counters=0, shift register=0.
  - rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - After release, a line already low is treated as a new start edge.
- Latency: rx_valid rises 1 cycle after the mid-stop-bit sample, about 9.5 bit times + 3 clocks after the rx falling edge.
- No parity, no break detection, no baud auto-detect.

Test Plan (CLK_FREQ=100_000_000, BAUD_RATE=25_000_000, CLKS_PER_BIT=4, 10 ns clk):
- Single byte: drive 0x48 ('H', LSB-first 0,0,0,1,0,0,1,0) with rx_ready=0 -> busy high through the frame; state walks START->DATA->STOP->IDLE; rx_data=0x48; rx_valid=1 held until rx_ready is pulsed, then 0 the next cycle; frame_err=0, overrun=0.
- Back-to-back: 0x55 then 0xA3 with no idle gap and rx_ready=1 -> two rx_valid assertions with rx_data 0x55 then 0xA3; no overrun.
- False start: drive rx low for 1 bit-clock (10 ns glitch), then high -> state returns to IDLE from START; rx_valid, frame_err and overrun stay 0.
- Framing error: frame 0x3C with stop bit driven 0 -> frame_err is a single-cycle pulse; rx_valid=0; rx_data unchanged (0x00 after reset).
- Overrun: receive 0x11 with rx_ready=0, then 0x22 -> overrun pulses once; rx_data remains 0x11; rx_valid stays 1.
- Reset mid-frame plus loopback: assert rst_n=0 during DATA -> all outputs reset, state=IDLE. Then connect uart_tx.tx to rx and send 0x48 -> rx_data=0x48 received.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a two-flop synchroniser, mid-bit sampling and a valid/ready output register.
// Latency: rx_valid rises 1 clk after the mid-stop-bit sample (~9.5 bit times + 3 clks after the rx falling edge).
// Backpressure: a byte completed while rx_valid is held without a handshake is dropped and overrun pulses.
// Ports: clk, rst_n (async, active-low), rx (async serial in, idles high),
//        rx_data/rx_valid/rx_ready (byte output handshake), frame_err/overrun (1-cycle pulses), busy.
module uart_rx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    // Below 4 clocks per bit the half-bit point and the synchroniser delay collide.
    if (CLKS_PER_BIT < 4) begin : g_bad_baud
        $error("uart_rx: CLKS_PER_BIT must be >= 4");
    end

    localparam logic [3:0] IDLE  = 4'b0001;
    localparam logic [3:0] START = 4'b0010;
    localparam logic [3:0] DATA  = 4'b0100;
    localparam logic [3:0] STOP  = 4'b1000;

    logic             rx_meta_q, rx_s_q;
    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             hs;

    // Exposed under this name for hierarchical observation.
    logic [3:0]       state;
    assign state = state_q;

    // Both synchroniser flops reset high so an idle line never looks like a start edge
    // right after reset; a line that is genuinely low still is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign hs = valid_q && rx_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;

        if (hs) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;     // glitch, not a real start bit
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};   // LSB arrives first
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                // Re-arm at mid-stop so a start bit immediately after the stop bit is caught.
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s_q) begin
                        if (!valid_q || hs) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at 4 clocks per bit.
// Latency: n/a (bench).
// Backpressure: rx_ready is driven per test; received bytes are checked against an expected-byte queue.
module tb_uart_rx;

    localparam int CPB = 4;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx #(
        .CLK_FREQ (100_000_000),
        .BAUD_RATE(25_000_000)
    ) DUT (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Monitor-owned observations.
    logic [7:0] obs_q[$];
    logic [3:0] state_log[$];
    logic [3:0] last_state = 4'b0001;
    int ferr_cycles = 0;
    int ovr_cycles  = 0;

    // Bench-owned expectations.
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) ferr_cycles++;
            if (overrun)   ovr_cycles++;
            if (rx_valid && rx_ready) obs_q.push_back(rx_data);
            if (DUT.state != last_state) begin
                state_log.push_back(DUT.state);
                last_state = DUT.state;
            end
        end else begin
            last_state = 4'b0001;
        end
    end

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_ferr;
        int         exp_bytes;
    } vec_t;

    vec_t vecs[6];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) cyc();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic wait_valid(input int max_cyc);
        int n;
        n = 0;
        while (!rx_valid && n < max_cyc) begin
            cyc();
            n++;
        end
        if (!rx_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_valid: rx_valid still 0 after %0d cycles, expected 1", max_cyc);
        end
    endtask

    task automatic drain_sb();
        logic [7:0] o;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_extra: got byte 0x%0h, expected none", o);
            end else begin
                chk("sb_byte", {24'h0, o}, {24'h0, exp_q.pop_front()});
            end
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, o0, m;

        vecs[0] = '{8'h48, 1'b1, 0, 1};
        vecs[1] = '{8'h00, 1'b1, 0, 1};
        vecs[2] = '{8'hFF, 1'b1, 0, 1};
        vecs[3] = '{8'hA5, 1'b1, 0, 1};
        vecs[4] = '{8'h3C, 1'b0, 1, 0};
        vecs[5] = '{8'h81, 1'b1, 0, 1};

        rx = 1'b1;
        rx_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) cyc();

        // Reset state
        chk("rst_rx_data", {24'h0, rx_data}, 32'h0);
        chk("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        chk("rst_frame_err", {31'h0, frame_err}, 32'h0);
        chk("rst_overrun", {31'h0, overrun}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_state", {28'h0, DUT.state}, 32'h1);
        rst_n = 1'b1;
        repeat (2) cyc();

        // Framing error right after reset: rx_data must stay 0x00
        f0 = ferr_cycles;
        o0 = ovr_cycles;
        send_frame(8'h3C, 1'b0);
        repeat (10) cyc();
        chk("ferr_pulse_cycles", ferr_cycles - f0, 1);
        chk("ferr_ovr", ovr_cycles - o0, 0);
        chk("ferr_rx_valid", {31'h0, rx_valid}, 32'h0);
        chk("ferr_rx_data", {24'h0, rx_data}, 32'h0);

        // Single byte 0x48 held until consumed
        exp_q.push_back(8'h48);
        m = state_log.size();
        f0 = ferr_cycles;
        o0 = ovr_cycles;
        fork
            send_frame(8'h48, 1'b1);
            begin
                repeat (20) cyc();
                chk("single_busy_mid", {31'h0, busy}, 32'h1);
            end
        join
        wait_valid(10);
        chk("single_rx_data", {24'h0, rx_data}, 32'h48);
        repeat (5) cyc();
        chk("single_valid_held", {31'h0, rx_valid}, 32'h1);
        chk("single_busy_idle", {31'h0, busy}, 32'h0);
        chk("single_walk_len", state_log.size() - m, 4);
        if (state_log.size() - m == 4) begin
            chk("single_walk_0", {28'h0, state_log[m]},   32'h2);
            chk("single_walk_1", {28'h0, state_log[m+1]}, 32'h4);
            chk("single_walk_2", {28'h0, state_log[m+2]}, 32'h8);
            chk("single_walk_3", {28'h0, state_log[m+3]}, 32'h1);
        end
        rx_ready = 1'b1;
        cyc();
        rx_ready = 1'b0;
        chk("single_valid_clear", {31'h0, rx_valid}, 32'h0);
        drain_sb();
        chk("single_ferr", ferr_cycles - f0, 0);
        chk("single_ovr", ovr_cycles - o0, 0);

        // Back-to-back frames, no idle gap, consumer always ready
        rx_ready = 1'b1;
        o0 = ovr_cycles;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hA3);
        send_frame(8'h55, 1'b1);
        send_frame(8'hA3, 1'b1);
        repeat (6) cyc();
        drain_sb();
        chk("b2b_pending", exp_q.size(), 0);
        chk("b2b_ovr", ovr_cycles - o0, 0);

        // False start: one-clock glitch low
        rx_ready = 1'b0;
        m = state_log.size();
        f0 = ferr_cycles;
        o0 = ovr_cycles;
        rx = 1'b0;
        cyc();
        rx = 1'b1;
        repeat (10) cyc();
        chk("fstart_log_len", state_log.size() - m, 2);
        if (state_log.size() - m == 2) begin
            chk("fstart_to_start", {28'h0, state_log[m]},   32'h2);
            chk("fstart_to_idle",  {28'h0, state_log[m+1]}, 32'h1);
        end
        chk("fstart_valid", {31'h0, rx_valid}, 32'h0);
        chk("fstart_ferr", ferr_cycles - f0, 0);
        chk("fstart_ovr", ovr_cycles - o0, 0);

        // Overrun: second byte arrives while the first is still unconsumed
        exp_q.push_back(8'h11);
        o0 = ovr_cycles;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (4) cyc();
        chk("ovr_pulse_cycles", ovr_cycles - o0, 1);
        chk("ovr_rx_data", {24'h0, rx_data}, 32'h11);
        chk("ovr_rx_valid", {31'h0, rx_valid}, 32'h1);
        rx_ready = 1'b1;
        cyc();
        rx_ready = 1'b0;
        drain_sb();
        chk("ovr_pending", exp_q.size(), 0);

        // Table-driven frames, consumer always ready
        rx_ready = 1'b1;
        foreach (vecs[i]) begin
            int h0;
            f0 = ferr_cycles;
            h0 = obs_q.size();
            if (vecs[i].stop_bit) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop_bit);
            repeat (10) cyc();
            chk($sformatf("vec%0d_bytes", i), obs_q.size() - h0, vecs[i].exp_bytes);
            drain_sb();
            chk($sformatf("vec%0d_ferr", i), ferr_cycles - f0, vecs[i].exp_ferr);
        end
        chk("vec_pending", exp_q.size(), 0);

        // Reset mid-frame with an unconsumed byte present
        rx_ready = 1'b0;
        send_frame(8'h5A, 1'b1);
        repeat (4) cyc();
        chk("mrst_pre_valid", {31'h0, rx_valid}, 32'h1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        chk("mrst_pre_state", {28'h0, DUT.state}, 32'h4);
        rst_n = 1'b0;
        #1;
        chk("mrst_state", {28'h0, DUT.state}, 32'h1);
        chk("mrst_rx_data", {24'h0, rx_data}, 32'h0);
        chk("mrst_rx_valid", {31'h0, rx_valid}, 32'h0);
        chk("mrst_busy", {31'h0, busy}, 32'h0);
        chk("mrst_ferr_ovr", {30'h0, frame_err, overrun}, 32'h0);
        rx = 1'b1;
        cyc();
        rst_n = 1'b1;
        repeat (3) cyc();

        // Loopback-style transmit of 0x48 after reset
        rx_ready = 1'b1;
        exp_q.push_back(8'h48);
        send_frame(8'h48, 1'b1);
        repeat (8) cyc();
        drain_sb();
        chk("loop_pending", exp_q.size(), 0);
        chk("loop_rx_data", {24'h0, rx_data}, 32'h48);

        chk("final_obs_empty", obs_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
